// File: rtl/branch_history_predictor.sv
// Branch history predictor: table of 2-bit saturating counters indexed by
// fetch PC (bimodal) or PC XOR global history (gshare). Prediction is
// combinational; updates from the resolve stage are registered. Saturating
// branch/mispredict counters provide performance visibility.
module branch_history_predictor #(
  parameter int          PC_W    = 32,
  parameter int          IDX_W   = 5,
  parameter int          MODE    = 0,
  parameter int          GHR_W   = 4,
  parameter logic [1:0]  INIT_ST = 2'b01,
  parameter int          CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic [PC_W-1:0]  pred_pc,
  input  logic             pred_is_br,
  output logic             pred_taken,
  output logic [IDX_W-1:0] pred_idx,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  input  logic             upd_mispred,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_br,
  output logic [CNT_W-1:0] cnt_miss
);

  localparam int               N_ENT   = 2 ** IDX_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Next state of a 2-bit saturating counter after one resolved outcome.
  function automatic logic [1:0] sat_next(input logic [1:0] cur, input logic taken);
    logic [1:0] nxt;
    if (taken) begin
      nxt = (cur == 2'b11) ? 2'b11 : cur + 2'b01;
    end else begin
      nxt = (cur == 2'b00) ? 2'b00 : cur - 2'b01;
    end
    return nxt;
  endfunction

  logic [1:0]       table_r [N_ENT];
  logic [GHR_W-1:0] ghr_r;
  logic [CNT_W-1:0] cnt_br_r;
  logic [CNT_W-1:0] cnt_miss_r;

  logic [IDX_W-1:0] pc_idx_s;
  logic [IDX_W-1:0] ghr_ext_s;
  logic [IDX_W-1:0] pred_idx_s;
  logic             pred_taken_s;
  logic             upd_accept_s;
  logic             unused_s;

  // PC bits outside the index field do not take part in prediction.
  assign unused_s = ^{pred_pc[PC_W-1:IDX_W+2], pred_pc[1:0]};

  // An update is only taken when the pipeline is not stalled.
  assign upd_accept_s = upd_valid & ~stall;

  // Form the table index: word-aligned PC bits, optionally hashed with history.
  always_comb begin
    pc_idx_s                = pred_pc[IDX_W+1:2];
    ghr_ext_s               = {IDX_W{1'b0}};
    ghr_ext_s[GHR_W-1:0]    = ghr_r;
    if (MODE == 32'd1) begin
      pred_idx_s = pc_idx_s ^ ghr_ext_s;
    end else begin
      pred_idx_s = pc_idx_s;
    end
  end

  // Zero-latency prediction; no bypass of a same-cycle update.
  assign pred_taken_s = pred_is_br & table_r[pred_idx_s][1];

  assign pred_taken = pred_taken_s;
  assign pred_idx   = pred_idx_s;
  assign cnt_br     = cnt_br_r;
  assign cnt_miss   = cnt_miss_r;

  // Counter table: reset loop to the initial state, then saturating updates.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_ENT; i++) begin
        table_r[i] <= INIT_ST;
      end
    end else if (upd_accept_s) begin
      table_r[upd_idx] <= sat_next(table_r[upd_idx], upd_taken);
    end
  end

  // Non-speculative global history: shift in each resolved outcome.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ghr_r <= {GHR_W{1'b0}};
    end else if (upd_accept_s) begin
      ghr_r <= GHR_W'({ghr_r, upd_taken});
    end
  end

  // Saturating performance counters; clear wins over increment and stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_br_r   <= {CNT_W{1'b0}};
      cnt_miss_r <= {CNT_W{1'b0}};
    end else if (cnt_clr) begin
      cnt_br_r   <= {CNT_W{1'b0}};
      cnt_miss_r <= {CNT_W{1'b0}};
    end else if (upd_accept_s) begin
      if (cnt_br_r != CNT_MAX) begin
        cnt_br_r <= cnt_br_r + CNT_ONE;
      end
      if (upd_mispred && (cnt_miss_r != CNT_MAX)) begin
        cnt_miss_r <= cnt_miss_r + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_branch_history_predictor.sv
// Self-checking bench: one bimodal and one gshare instance share stimulus.
// Directed vector table, hand sequences for gshare aliasing, mid-stream
// reset and counter saturation, plus a randomized phase against a model.
module tb_branch_history_predictor;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic [31:0] pred_pc;
  logic        pred_is_br;
  logic        upd_valid;
  logic [4:0]  upd_idx;
  logic        upd_taken;
  logic        upd_mispred;
  logic        cnt_clr;

  logic        pt0, pt1;
  logic [4:0]  idx0, idx1;
  logic [15:0] br0, br1, miss0, miss1;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int m_tab [32];
  int m_ghr;
  int m_br;
  int m_miss;

  branch_history_predictor #(.MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .pred_pc(pred_pc),
    .pred_is_br(pred_is_br), .pred_taken(pt0), .pred_idx(idx0),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
    .upd_mispred(upd_mispred), .cnt_clr(cnt_clr), .cnt_br(br0), .cnt_miss(miss0)
  );

  branch_history_predictor #(.MODE(1), .GHR_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .pred_pc(pred_pc),
    .pred_is_br(pred_is_br), .pred_taken(pt1), .pred_idx(idx1),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
    .upd_mispred(upd_mispred), .cnt_clr(cnt_clr), .cnt_br(br1), .cnt_miss(miss1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model reaction to one clock edge, from the rules of the predictor.
  task automatic model_edge();
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m_tab[i] = 1;
      m_ghr  = 0;
      m_br   = 0;
      m_miss = 0;
    end else begin
      if (!stall && upd_valid) begin
        if (upd_taken) m_tab[upd_idx] = (m_tab[upd_idx] >= 3) ? 3 : m_tab[upd_idx] + 1;
        else           m_tab[upd_idx] = (m_tab[upd_idx] <= 0) ? 0 : m_tab[upd_idx] - 1;
        m_ghr = (m_ghr * 2 + int'(upd_taken)) % 16;
        if (!cnt_clr) begin
          m_br = (m_br >= 65535) ? 65535 : m_br + 1;
          if (upd_mispred) m_miss = (m_miss >= 65535) ? 65535 : m_miss + 1;
        end
      end
      if (cnt_clr) begin
        m_br   = 0;
        m_miss = 0;
      end
    end
  endtask

  // Compare every output of both instances with the model.
  task automatic check_model(input string tag);
    int i0, i1;
    i0 = int'(pred_pc / 4) % 32;
    i1 = i0 ^ m_ghr;
    chk({tag, "_idx0"}, 32'(idx0), 32'(i0));
    chk({tag, "_idx1"}, 32'(idx1), 32'(i1));
    chk({tag, "_pt0"}, 32'(pt0), 32'(pred_is_br && m_tab[i0] >= 2));
    chk({tag, "_pt1"}, 32'(pt1), 32'(pred_is_br && m_tab[i1] >= 2));
    chk({tag, "_br0"}, 32'(br0), 32'(m_br));
    chk({tag, "_miss0"}, 32'(miss0), 32'(m_miss));
    chk({tag, "_br1"}, 32'(br1), 32'(m_br));
    chk({tag, "_miss1"}, 32'(miss1), 32'(m_miss));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic st, input logic v, input logic [4:0] ix, input logic t,
                       input logic mp, input logic clr, input logic [31:0] pc, input logic br);
    stall = st; upd_valid = v; upd_idx = ix; upd_taken = t;
    upd_mispred = mp; cnt_clr = clr; pred_pc = pc; pred_is_br = br;
  endtask

  typedef struct {
    logic        stall, valid;
    logic [4:0]  idx;
    logic        taken, mispred, clr;
    logic [31:0] pc;
    logic        is_br;
    logic        exp_pt;
    logic [4:0]  exp_idx;
    logic [15:0] exp_br, exp_miss;
  } vec_t;

  vec_t vecs [18];

  initial begin
    // stall valid idx taken misp clr pc is_br | pt idx br miss (pre-edge, bimodal)
    vecs[0]  = '{1'b0, 1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 32'h40, 1'b1, 1'b0, 5'h10, 16'd0, 16'd0};
    vecs[1]  = '{1'b0, 1'b1, 5'h10, 1'b1, 1'b1, 1'b0, 32'h40, 1'b1, 1'b0, 5'h10, 16'd0, 16'd0};
    vecs[2]  = '{1'b0, 1'b1, 5'h10, 1'b1, 1'b0, 1'b0, 32'h40, 1'b1, 1'b1, 5'h10, 16'd1, 16'd1};
    vecs[3]  = '{1'b0, 1'b1, 5'h10, 1'b1, 1'b0, 1'b0, 32'h40, 1'b1, 1'b1, 5'h10, 16'd2, 16'd1};
    vecs[4]  = '{1'b0, 1'b1, 5'h10, 1'b0, 1'b1, 1'b0, 32'h40, 1'b1, 1'b1, 5'h10, 16'd3, 16'd1};
    vecs[5]  = '{1'b0, 1'b1, 5'h10, 1'b0, 1'b0, 1'b0, 32'h40, 1'b1, 1'b1, 5'h10, 16'd4, 16'd2};
    vecs[6]  = '{1'b0, 1'b0, 5'h10, 1'b0, 1'b0, 1'b0, 32'h40, 1'b1, 1'b0, 5'h10, 16'd5, 16'd2};
    vecs[7]  = '{1'b1, 1'b1, 5'h10, 1'b1, 1'b1, 1'b0, 32'h40, 1'b1, 1'b0, 5'h10, 16'd5, 16'd2};
    vecs[8]  = '{1'b0, 1'b0, 5'h10, 1'b0, 1'b0, 1'b0, 32'h40, 1'b1, 1'b0, 5'h10, 16'd5, 16'd2};
    vecs[9]  = '{1'b0, 1'b1, 5'h10, 1'b1, 1'b0, 1'b0, 32'h40, 1'b0, 1'b0, 5'h10, 16'd5, 16'd2};
    vecs[10] = '{1'b0, 1'b0, 5'h10, 1'b0, 1'b0, 1'b0, 32'h40, 1'b0, 1'b0, 5'h10, 16'd6, 16'd2};
    vecs[11] = '{1'b0, 1'b0, 5'h10, 1'b0, 1'b0, 1'b0, 32'h44, 1'b1, 1'b0, 5'h11, 16'd6, 16'd2};
    vecs[12] = '{1'b0, 1'b1, 5'h10, 1'b1, 1'b1, 1'b1, 32'h40, 1'b1, 1'b1, 5'h10, 16'd6, 16'd2};
    vecs[13] = '{1'b0, 1'b0, 5'h10, 1'b0, 1'b0, 1'b0, 32'h40, 1'b0, 1'b0, 5'h10, 16'd0, 16'd0};
    vecs[14] = '{1'b0, 1'b1, 5'h03, 1'b1, 1'b1, 1'b0, 32'h40, 1'b1, 1'b1, 5'h10, 16'd0, 16'd0};
    vecs[15] = '{1'b1, 1'b0, 5'h03, 1'b0, 1'b0, 1'b1, 32'h40, 1'b1, 1'b1, 5'h10, 16'd1, 16'd1};
    vecs[16] = '{1'b0, 1'b0, 5'h03, 1'b0, 1'b0, 1'b0, 32'h0C, 1'b1, 1'b1, 5'h03, 16'd0, 16'd0};
    vecs[17] = '{1'b0, 1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 32'h12345678, 1'b1, 1'b0, 5'h1E, 16'd0, 16'd0};

    for (int i = 0; i < 32; i++) m_tab[i] = 0;
    m_ghr = 0; m_br = 0; m_miss = 0;

    // Reset held for two cycles with everything else active
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 5'h10, 1'b1, 1'b1, 1'b1, 32'h40, 1'b1);
    cycle();
    cycle();
    rst_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].stall, vecs[i].valid, vecs[i].idx, vecs[i].taken,
            vecs[i].mispred, vecs[i].clr, vecs[i].pc, vecs[i].is_br);
      #1;
      chk($sformatf("vec%0d_pt", i), 32'(pt0), 32'(vecs[i].exp_pt));
      chk($sformatf("vec%0d_idx", i), 32'(idx0), 32'(vecs[i].exp_idx));
      chk($sformatf("vec%0d_br", i), 32'(br0), 32'(vecs[i].exp_br));
      chk($sformatf("vec%0d_miss", i), 32'(miss0), 32'(vecs[i].exp_miss));
      check_model($sformatf("vec%0d", i));
      cycle();
    end

    // gshare: outcomes T,T,N,T leave history 1101
    drive(1'b0, 1'b1, 5'h05, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0); cycle();
    drive(1'b0, 1'b1, 5'h05, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0); cycle();
    drive(1'b0, 1'b1, 5'h05, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0); cycle();
    drive(1'b0, 1'b1, 5'h05, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0); cycle();
    drive(1'b0, 1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 32'h40, 1'b1); #1;
    chk("gshare_idx_1d", 32'(idx1), 32'h1D);
    check_model("gshare_a");
    // Two not-taken updates to 0x1D; history becomes 0100
    drive(1'b0, 1'b1, 5'h1D, 1'b0, 1'b0, 1'b0, 32'h40, 1'b1); cycle();
    drive(1'b0, 1'b1, 5'h1D, 1'b0, 1'b0, 1'b0, 32'h40, 1'b1); cycle();
    drive(1'b0, 1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 32'h50, 1'b1); #1;
    chk("gshare_alias_idx10", 32'(idx1), 32'h10);
    chk("gshare_alias_pt10", 32'(pt1), 32'h1);
    check_model("gshare_b");
    drive(1'b0, 1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 32'h64, 1'b1); #1;
    chk("gshare_idx1d_after", 32'(idx1), 32'h1D);
    chk("gshare_pt1d_after", 32'(pt1), 32'h0);
    check_model("gshare_c");
    cycle();

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      drive(($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)),
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, ($urandom_range(0, 49) == 0),
            $urandom, ($urandom_range(0, 3) != 0));
      #1;
      check_model("rand");
      cycle();
    end

    // Mid-stream reset overrides stall, clear and update
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 5'h10, 1'b1, 1'b1, 1'b1, 32'h40, 1'b1);
    cycle();
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 32'h40, 1'b1); #1;
    chk("rst_pt0", 32'(pt0), 32'h0);
    chk("rst_idx1", 32'(idx1), 32'h10);
    chk("rst_pt1", 32'(pt1), 32'h0);
    chk("rst_br", 32'(br1), 32'h0);
    check_model("rst");
    cycle();

    // Counter saturation: more accepted mispredicted updates than 2^16
    for (int n = 0; n < 66000; n++) begin
      drive(1'b0, 1'b1, 5'($urandom_range(0, 31)), $urandom_range(0, 1) == 1, 1'b1, 1'b0,
            32'h40, 1'b1);
      cycle();
    end
    drive(1'b0, 1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 32'h40, 1'b1); #1;
    chk("sat_br0", 32'(br0), 32'hFFFF);
    chk("sat_miss0", 32'(miss0), 32'hFFFF);
    chk("sat_miss1", 32'(miss1), 32'hFFFF);
    check_model("sat");

    // Clear together with an accepted update
    drive(1'b0, 1'b1, 5'h02, 1'b1, 1'b1, 1'b1, 32'h40, 1'b1);
    cycle();
    drive(1'b0, 1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 32'h40, 1'b1); #1;
    chk("clr_br0", 32'(br0), 32'h0);
    chk("clr_miss0", 32'(miss0), 32'h0);
    check_model("clr");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
